// File: rtl/jtframe_z80_arb_pkg.sv
// Shared definitions for the Z80 / external-master shared RAM arbiter.
package jtframe_z80_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DATA = 2'd2
  } arb_st_e;

  localparam logic OWN_Z80   = 1'b0;
  localparam logic OWN_EXT   = 1'b1;
  localparam int   ARB_SLOTS = 3;
endpackage

// File: rtl/jtframe_z80_shram_arb.sv
// Round-robin arbiter of one synchronous single-port RAM between a cen-gated Z80
// and a req/ack external master. Every access holds the RAM for three clocks.
module jtframe_z80_shram_arb
  import jtframe_z80_arb_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = 8
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          z80_cs,
  input  logic          z80_rd_n,
  input  logic          z80_wr_n,
  input  logic [AW-1:0] z80_addr,
  input  logic [DW-1:0] z80_dout,
  output logic [DW-1:0] z80_din,
  output logic          z80_busy,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_din,
  output logic [DW-1:0] ext_dout,
  output logic          ext_ack,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);
  arb_st_e st, st_nx;
  logic    owner, last_owner, served;
  logic    z80_pend, ext_pend, gnt_z80, gnt_ext;

  // served blocks a second access while the same Z80 bus cycle keeps cs high
  assign z80_pend = z80_cs & ~served & (~z80_rd_n | ~z80_wr_n);
  assign ext_pend = ext_req & (st == ST_IDLE);
  assign z80_busy = z80_cs & ~served;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= ST_IDLE;
    else        st <= st_nx;

  always_comb begin
    st_nx = st;
    case (st)
      ST_IDLE: if (gnt_z80 | gnt_ext) st_nx = ST_ACC;
      ST_ACC:  st_nx = ST_DATA;
      ST_DATA: st_nx = ST_IDLE;
      default: st_nx = ST_IDLE;
    endcase
  end

  // on a tie the requester that did not go last wins
  always_comb begin
    gnt_z80 = 1'b0;
    gnt_ext = 1'b0;
    if (st == ST_IDLE) begin
      gnt_z80 = z80_pend & (~ext_pend | (last_owner == OWN_EXT));
      gnt_ext = ext_pend & (~z80_pend | (last_owner == OWN_Z80));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_Z80;
      last_owner <= OWN_EXT;
      served     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_we     <= 1'b0;
      z80_din    <= '0;
      ext_dout   <= '0;
      ext_ack    <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (gnt_z80) begin
        owner      <= OWN_Z80;
        last_owner <= OWN_Z80;
        ram_addr   <= z80_addr;
        ram_din    <= z80_dout;
        ram_we     <= ~z80_wr_n;
      end else if (gnt_ext) begin
        owner      <= OWN_EXT;
        last_owner <= OWN_EXT;
        ram_addr   <= ext_addr;
        ram_din    <= ext_din;
        ram_we     <= ext_we;
      end
      if (st == ST_DATA) begin
        if (owner == OWN_Z80) z80_din  <= ram_q;
        else                  ext_dout <= ram_q;
      end
      ext_ack <= (st == ST_DATA) && (owner == OWN_EXT);
      // an aborted Z80 cycle (cs already low) never marks itself served
      if (!z80_cs)                                      served <= 1'b0;
      else if ((st == ST_DATA) && (owner == OWN_Z80))   served <= 1'b1;
    end
  end
endmodule

// File: tb/tb_jtframe_z80_shram_arb.sv
// Scoreboard bench for the shared RAM arbiter with a behavioural synchronous RAM.
module tb_jtframe_z80_shram_arb;
  import jtframe_z80_arb_pkg::*;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          z80_cs = 0, z80_rd_n = 1, z80_wr_n = 1;
  logic [AW-1:0] z80_addr = '0;
  logic [DW-1:0] z80_dout = '0, z80_din;
  logic          z80_busy;
  logic          ext_req = 0, ext_we = 0, ext_ack;
  logic [AW-1:0] ext_addr = '0, ram_addr;
  logic [DW-1:0] ext_din = '0, ext_dout, ram_din, ram_q;
  logic          ram_we;

  int total = 0, bad = 0;
  logic [DW-1:0] zq[$], eq[$];

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_we = 0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always #5 clk = ~clk;

  jtframe_z80_shram_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .z80_cs(z80_cs), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
    .z80_addr(z80_addr), .z80_dout(z80_dout), .z80_din(z80_din), .z80_busy(z80_busy),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_din(ext_din),
    .ext_dout(ext_dout), .ext_ack(ext_ack),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_q(ram_q)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (pre_we) mem[pre_addr] <= pre_data;
    ram_q <= mem[ram_addr];
  end

  task preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 0;
  endtask

  task do_reset;
    rst_n = 0;
    z80_cs = 0; z80_rd_n = 1; z80_wr_n = 1; ext_req = 0; ext_we = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // drives one external transfer, returns cycles until ack (-1 on timeout)
  task ext_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                output int lat, output int we_cnt);
    ext_req = 1; ext_we = we; ext_addr = a; ext_din = d;
    lat = 0; we_cnt = 0;
    do begin
      @(negedge clk); lat++;
      if (ram_we) we_cnt++;
    end while (!ext_ack && lat < 20);
    if (!ext_ack) lat = -1;
    ext_req = 0; ext_we = 0;
  endtask

  task test_reset;
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    total++;
    if ({z80_din, ext_dout, ram_addr, ram_din} !== '0) begin
      bad++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", z80_din, ext_dout, ram_addr, ram_din);
    end
    total++;
    if ({ram_we, ext_ack, z80_busy} !== 3'b000) begin
      bad++; $display("FAIL reset_ctl: got we/ack/busy=%b%b%b want 000", ram_we, ext_ack, z80_busy);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task test_z80_read;
    int cyc;
    logic [DW-1:0] exp;
    preload(11'h123, 8'h5A);
    z80_cs = 1; z80_rd_n = 0; z80_addr = 11'h123; zq.push_back(8'h5A);
    #1;
    total++;
    if (z80_busy !== 1'b1) begin bad++; $display("FAIL zrd_busy_now: got %b want 1", z80_busy); end
    @(negedge clk); cyc = 1;
    total++;
    if (ram_addr !== 11'h123) begin bad++; $display("FAIL zrd_addr: got %h want 123", ram_addr); end
    while (z80_busy && cyc < 20) begin @(negedge clk); cyc++; end
    total++;
    if (cyc !== ARB_SLOTS) begin bad++; $display("FAIL zrd_latency: got %0d want %0d", cyc, ARB_SLOTS); end
    exp = zq.pop_front();
    total++;
    if (z80_din !== exp) begin bad++; $display("FAIL zrd_data: got %h want %h", z80_din, exp); end
    z80_addr = 11'h124;
    repeat (5) @(negedge clk);
    total++;
    if (ram_addr !== 11'h123 || z80_busy !== 1'b0) begin
      bad++; $display("FAIL zrd_single: got addr=%h busy=%b want 123/0", ram_addr, z80_busy);
    end
    z80_cs = 0; z80_rd_n = 1;
    @(negedge clk);
  endtask

  task test_ext_wr_rd;
    int lat, wc;
    logic [DW-1:0] exp;
    ext_xfer(1'b1, 11'h010, 8'h77, lat, wc);
    total++;
    if (lat !== ARB_SLOTS) begin bad++; $display("FAIL ewr_latency: got %0d want %0d", lat, ARB_SLOTS); end
    total++;
    if (wc !== 1) begin bad++; $display("FAIL ewr_we_pulse: got %0d cycles want 1", wc); end
    @(negedge clk);
    total++;
    if (ext_ack !== 1'b0) begin bad++; $display("FAIL ewr_ack_once: got %b want 0", ext_ack); end
    eq.push_back(8'h77);
    ext_xfer(1'b0, 11'h010, 8'h00, lat, wc);
    exp = eq.pop_front();
    total++;
    if (lat !== ARB_SLOTS || wc !== 0) begin
      bad++; $display("FAIL erd_timing: got lat=%0d we=%0d want %0d/0", lat, wc, ARB_SLOTS);
    end
    total++;
    if (ext_dout !== exp) begin bad++; $display("FAIL erd_data: got %h want %h", ext_dout, exp); end
    @(negedge clk);
  endtask

  task test_same_edge;
    int cyc, zc, ec;
    logic [DW-1:0] exp;
    do_reset();
    z80_cs = 1; z80_rd_n = 0; z80_addr = 11'h123; zq.push_back(8'h5A);
    ext_req = 1; ext_we = 0; ext_addr = 11'h010; eq.push_back(8'h77);
    cyc = 0; zc = -1; ec = -1;
    while (ec < 0 && cyc < 30) begin
      @(negedge clk); cyc++;
      if (zc < 0 && !z80_busy) zc = cyc;
      if (ext_ack) begin ec = cyc; ext_req = 0; end
    end
    total++;
    if (zc !== ARB_SLOTS) begin bad++; $display("FAIL tie_z80_first: got %0d want %0d", zc, ARB_SLOTS); end
    total++;
    if (ec !== 2*ARB_SLOTS) begin bad++; $display("FAIL tie_ext_latency: got %0d want %0d", ec, 2*ARB_SLOTS); end
    exp = zq.pop_front();
    total++;
    if (z80_din !== exp) begin bad++; $display("FAIL tie_z80_data: got %h want %h", z80_din, exp); end
    exp = eq.pop_front();
    total++;
    if (ext_dout !== exp) begin bad++; $display("FAIL tie_ext_data: got %h want %h", ext_dout, exp); end
    z80_cs = 0; z80_rd_n = 1;
    @(negedge clk);
  endtask

  task test_round_robin;
    logic [AW-1:0] ga[$], exp_a[$];
    int gc[$];
    for (int i = 0; i < 4; i++) begin
      preload(11'h100 + 11'(i), 8'h80 + 8'(i));
      preload(11'h200 + 11'(i), 8'h90 + 8'(i));
      exp_a.push_back(11'h100 + 11'(i));
      exp_a.push_back(11'h200 + 11'(i));
    end
    do_reset();
    fork
      begin : z80_drv
        int n;
        logic [DW-1:0] e;
        for (int i = 0; i < 4; i++) begin
          z80_cs = 1; z80_rd_n = 0; z80_addr = 11'h100 + 11'(i); zq.push_back(8'h80 + 8'(i));
          n = 0;
          do begin @(negedge clk); n++; end while (z80_busy && n < 30);
          e = zq.pop_front();
          total++;
          if (z80_busy !== 1'b0 || z80_din !== e) begin
            bad++; $display("FAIL rr_z80_data%0d: got %h busy=%b want %h", i, z80_din, z80_busy, e);
          end
          z80_cs = 0; z80_rd_n = 1;
          @(negedge clk);
        end
      end
      begin : ext_drv
        int n;
        logic [DW-1:0] e;
        ext_req = 1; ext_we = 0;
        for (int j = 0; j < 4; j++) begin
          ext_addr = 11'h200 + 11'(j); eq.push_back(8'h90 + 8'(j));
          n = 0;
          do begin @(negedge clk); n++; end while (!ext_ack && n < 30);
          e = eq.pop_front();
          total++;
          if (ext_ack !== 1'b1 || ext_dout !== e) begin
            bad++; $display("FAIL rr_ext_data%0d: got %h ack=%b want %h", j, ext_dout, ext_ack, e);
          end
        end
        ext_req = 0;
      end
      begin : grant_mon
        logic [AW-1:0] prev;
        prev = ram_addr;
        for (int c = 1; c <= 40; c++) begin
          @(negedge clk);
          if (ram_addr !== prev) begin ga.push_back(ram_addr); gc.push_back(c); end
          prev = ram_addr;
        end
      end
    join
    total++;
    if (ga.size() !== 8) begin bad++; $display("FAIL rr_grant_count: got %0d want 8", ga.size()); end
    for (int k = 0; k < 8 && k < ga.size(); k++) begin
      total++;
      if (ga[k] !== exp_a[k]) begin bad++; $display("FAIL rr_order%0d: got %h want %h", k, ga[k], exp_a[k]); end
      if (k > 0) begin
        total++;
        if (gc[k] - gc[k-1] !== ARB_SLOTS) begin
          bad++; $display("FAIL rr_spacing%0d: got %0d want %0d", k, gc[k] - gc[k-1], ARB_SLOTS);
        end
      end
    end
  endtask

  task test_z80_write;
    int n;
    int we_seen;
    z80_cs = 1; z80_rd_n = 1; z80_wr_n = 1; z80_addr = 11'h050; z80_dout = 8'hC3;
    we_seen = 0;
    repeat (4) begin @(negedge clk); if (ram_we || ram_addr === 11'h050) we_seen++; end
    total++;
    if (we_seen !== 0 || z80_busy !== 1'b1) begin
      bad++; $display("FAIL zwr_no_strobe: got grants=%0d busy=%b want 0/1", we_seen, z80_busy);
    end
    z80_wr_n = 0;
    @(negedge clk);
    total++;
    if (ram_we !== 1'b1 || ram_din !== 8'hC3 || ram_addr !== 11'h050) begin
      bad++; $display("FAIL zwr_grant: got we=%b din=%h addr=%h want 1/c3/050", ram_we, ram_din, ram_addr);
    end
    z80_dout = 8'h3C;
    n = 1;
    while (z80_busy && n < 20) begin @(negedge clk); n++; end
    total++;
    if (mem[11'h050] !== 8'hC3 || n !== ARB_SLOTS) begin
      bad++; $display("FAIL zwr_data: got mem=%h lat=%0d want c3/%0d", mem[11'h050], n, ARB_SLOTS);
    end
    z80_cs = 0; z80_wr_n = 1;
    @(negedge clk);
  endtask

  task test_reset_mid;
    int lat, wc;
    logic [DW-1:0] exp;
    preload(11'h060, 8'h11);
    ext_req = 1; ext_we = 1; ext_addr = 11'h060; ext_din = 8'hEE;
    @(negedge clk);
    total++;
    if (ram_we !== 1'b1) begin bad++; $display("FAIL rmid_we_before: got %b want 1", ram_we); end
    rst_n = 0;
    #1;
    total++;
    if (ram_we !== 1'b0 || ext_ack !== 1'b0 || ram_addr !== '0) begin
      bad++; $display("FAIL rmid_async: got we=%b ack=%b addr=%h want 0/0/0", ram_we, ext_ack, ram_addr);
    end
    ext_req = 0; ext_we = 0;
    @(negedge clk); @(negedge clk);
    total++;
    if (mem[11'h060] !== 8'h11) begin bad++; $display("FAIL rmid_no_write: got %h want 11", mem[11'h060]); end
    rst_n = 1;
    @(negedge clk);
    eq.push_back(8'h11);
    ext_xfer(1'b0, 11'h060, 8'h00, lat, wc);
    exp = eq.pop_front();
    total++;
    if (lat !== ARB_SLOTS || ext_dout !== exp) begin
      bad++; $display("FAIL rmid_fresh: got lat=%0d data=%h want %0d/%h", lat, ext_dout, ARB_SLOTS, exp);
    end
  endtask

  initial begin
    test_reset();
    test_z80_read();
    test_ext_wr_rd();
    test_same_edge();
    test_round_robin();
    test_z80_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtframe_z80_shram_arb.md
Name: jtframe_z80_shram_arb

Overview:
Arbitrates one single-port synchronous shared RAM between a cen-gated Z80 and an external master, such as a main CPU or DMA, using a req/ack handshake.
While a Z80 access is pending and unserved, it drives z80_busy into the dev_busy input of the Z80 wait generator, which stalls cpu_cen.
Round-robin arbitration prevents either requester from starving the other.
Sits between the sound/sub-CPU wrapper and the shared RAM instance.

Parameters:
AW, 11, shared RAM address width
DW, 8, data width

Ports:
clk       in   1   system clock
rst_n     in   1   reset, asynchronous, active-low
z80_cs    in   1   Z80 MREQ decoded to shared RAM
z80_rd_n  in   1   Z80 read strobe
z80_wr_n  in   1   Z80 write strobe
z80_addr  in   AW  Z80 address
z80_dout  in   DW  Z80 write data
z80_din   out  DW  registered read data to Z80
z80_busy  out  1   to wait generator dev_busy
ext_req   in   1   external request, level, held until ack
ext_we    in   1   external write
ext_addr  in   AW  external address
ext_din   in   DW  external write data
ext_dout  out  DW  registered read data to external master
ext_ack   out  1   one-clk completion pulse
ram_addr  out  AW  registered RAM address
ram_din   out  DW  registered RAM write data
ram_we    out  1   registered RAM write enable, one clk
ram_q     in   DW  RAM read data, valid 1 clk after addr sampled

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, served=0, last_owner=EXT.
- z80_pend = z80_cs & ~served & (~z80_rd_n | ~z80_wr_n). A Z80 cs with neither strobe low is not pending.
- ext_pend = ext_req & state==IDLE.
- z80_busy = z80_cs & ~served, combinational; the wait block registers it.
- FSM states: IDLE -> ACC -> DATA -> IDLE. Each access occupies the RAM for 3 clks.
- IDLE, at edge k:
  - If only one requester is pending, it wins.
  - If both are pending, the winner is the opposite of last_owner.
  - Register owner, ram_addr, and ram_din. Set ram_we = ~z80_wr_n for a Z80 grant, or ext_we for an external grant.
  - Update last_owner. Go to ACC.
- ACC, at edge k+1: RAM samples address/write; clear ram_we; go to DATA.
- DATA, at edge k+2:
  - Latch ram_q into z80_din or ext_dout according to owner. Write accesses also latch; the value is don't-care.
  - Z80 owner: set served if z80_cs is still high.
  - EXT owner: ext_ack=1 for the clk following k+2.
  - Go to IDLE.
- Write data and address are captured only at the grant edge. Later input changes do not affect the access in flight.
- served clears on the first edge where z80_cs=0. Consequently one Z80 bus cycle produces exactly one RAM access.
- Back-to-back external requests:
  - ext_req still high at the IDLE edge after ack is a new request.
  - If the Z80 is pending at that edge, the Z80 wins (round-robin).
  - Worst-case external wait is 3 clks plus its own 3 clks.
- Aborted Z80 request (z80_cs drops during ACC/DATA): the access completes, the RAM write still happens, and served is not set.
- ext_req dropped before ack is a protocol violation. The access still completes and ext_ack still pulses.
- Asynchronous reset mid-access: immediate return to reset values. ram_we drops asynchronously, so no partial write occurs after reset release.
- No combinational path from ram_q to any output.

Decomposition:
- Package jtframe_z80_arb_pkg holds:
  - state encoding ST_IDLE/ST_ACC/ST_DATA (2 bits);
  - owner constants OWN_Z80=0 and OWN_EXT=1;
  - the access-length constant ARB_SLOTS=3 used by the bench for latency checks.
- Single module; no sub-module needed. The RAM itself (jtframe_ram) is instantiated by the parent.

Test Plan:
- Reset then Z80 read of addr 0x123 (RAM holds 0x5A), rd_n low: z80_busy=1 immediately; ram_addr=0x123 after edge 1; z80_din=0x5A and z80_busy=0 after edge 3; no second access while z80_cs stays high.
- External write of 0x77 to 0x010, then external read of 0x010: ram_we pulses exactly 1 clk. ext_ack pulses once per access, and ext_dout=0x77 after the second ack.
- Z80 read and ext_req rise on the same edge after reset: Z80 is granted first (last_owner=EXT), ext is granted on the next IDLE, and ext_ack arrives 6 clks after the request.
- ext_req held high continuously while the Z80 issues repeated reads: grants alternate Z80/EXT every 3 clks, and no requester is skipped twice.
- Z80 write of 0xC3: cs asserted with wr_n high gives no grant. Once wr_n goes low, ram_we=1 with ram_din=0xC3. A changed z80_dout afterwards is not written.
- rst_n pulled low during ACC of an external write: ram_we=0 and ext_ack=0 immediately. After release, state is IDLE and a fresh request completes normally.
